matriz_scan_driver: RTL
=======================

Name: matriz_scan_driver

Overview:
- Physical-side driver for the 10x10 snake-game LED matrix.
- Consumes the flat 100-bit frame vector produced by the game-logic matrix builder.
- Time-multiplexes the frame onto a row-scanned LED array: one row active at a time, with a blanking gap between rows to suppress ghosting.
- Snapshots the frame at each frame boundary so the image never tears mid-scan.

Parameters:
- ROWS, 10, number of matrix rows (row_sel width).
- COLS, 10, number of matrix columns (col_data width); frame width is ROWS*COLS.
- DWELL, 1000, clock cycles each row is driven; must be >= 1.
- BLANK, 16, clock cycles all outputs are off between rows; must be >= 1.
- ACTIVE_LOW, 0, 1 inverts both row_sel and col_data at the pins (common-anode boards).

Ports:
- clock  input  1  system clock, rising edge.
- restart_n  input  1  asynchronous active-low reset.
- enable  input  1  scan enable.
- leds  input  ROWS*COLS  frame; bit r*COLS+c is row r, column c; 1 = lit.
- row_sel  output  ROWS  one-hot row strobe (polarity per ACTIVE_LOW).
- col_data  output  COLS  column data for the active row (polarity per ACTIVE_LOW).
- row_idx  output  4  index of the row currently in BLANK or DRIVE.
- frame_done  output  1  single-cycle pulse at the end of the last row's DRIVE.
- busy  output  1  high whenever not in IDLE.

Behaviour:
- Reset is asynchronous and active-low. While restart_n=0:
  - state=IDLE, row_idx=0, frame_done=0, busy=0.
  - Snapshot register=0, phase counter=0.
  - row_sel and col_data at their "off" level: all-0 if ACTIVE_LOW=0, all-1 if ACTIVE_LOW=1.
- Deasserting reset mid-scan leaves the block in IDLE; scanning restarts from row 0 with a fresh snapshot.
- Three states: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs off, busy=0.
  - enable=1 sampled at an edge: that edge loads the snapshot from leds, sets row_idx=0, clears the counter, and enters BLANK. busy rises the same edge (1 cycle latency from enable).
- BLANK:
  - Outputs off, busy=1.
  - Lasts exactly BLANK cycles, then enters DRIVE.
- DRIVE:
  - row_sel has only bit row_idx active.
  - col_data = snapshot[row_idx*COLS +: COLS], bit c driving column c.
  - Lasts exactly DWELL cycles.
- At the last DRIVE cycle of row r < ROWS-1:
  - enable=1: row_idx=r+1, enter BLANK.
  - enable=0: enter IDLE. The frame is abandoned and frame_done is not pulsed.
- At the last DRIVE cycle of row ROWS-1:
  - frame_done=1 for exactly that one cycle, registered and coincident with the last DRIVE cycle.
  - enable=1: reload snapshot from leds, row_idx=0, enter BLANK.
  - enable=0: enter IDLE.
- enable is sampled only at row boundaries and in IDLE. Toggling enable during BLANK or DRIVE has no effect on the current row.
- Changes on leds between snapshots have no effect on the outputs.
- Frame period with enable held high is ROWS*(BLANK+DWELL) cycles, with no extra gap cycles.
- Counter width is clog2(max(DWELL,BLANK)). The counter runs 0..N-1 and clears on every phase change; no wrap beyond N-1.
- Never more than one row_sel bit active.
- The outputs never show a row's data in the same cycle as another row's strobe.
- All outputs are registered.

Test Plan:
- Reset and idle. Params ROWS=COLS=10, DWELL=4, BLANK=2, ACTIVE_LOW=0. Hold restart_n=0 with leds = all-ones, then release with enable=0 for 20 cycles -> row_sel=0, col_data=0, busy=0, frame_done=0 throughout.
- Single-pixel scan. leds bit 0x23 (35) set only, enable=1 -> busy rises 1 cycle later. For each row: 2 blank cycles with all outputs 0, then 4 cycles with row_sel = 1<<r. During row 3's dwell, col_data = 10'b0000100000; it is 0 on all other rows.
- Frame timing. enable held high for 200 cycles -> frame_done pulses at cycles 60, 120 and 180 after the IDLE exit, each 1 cycle wide and coincident with row_sel[9].
- Snapshot isolation. Change leds from bit 5 to bit 95 during row 2 of frame 1 -> frame 1 keeps showing only row 0/col 5. Frame 2 shows only row 9/col 5.
- Enable drop. Deassert enable during row 4's dwell -> row 4 completes its 4 cycles, then IDLE with outputs off, no frame_done. Re-enable -> scan restarts at row 0.
- Async reset and polarity. Assert restart_n=0 mid-DRIVE without a clock edge -> outputs off immediately. With ACTIVE_LOW=1, repeat the single-pixel scan -> row_sel and col_data are the bitwise inverse of the ACTIVE_LOW=0 values, and idle/blank is all-ones.

Source files
------------

// File: rtl/matriz_scan_driver.sv
// matriz_scan_driver: row-scanned driver for the snake-game LED matrix.
// The frame vector is captured at each frame boundary, then shown one row at a
// time. Each row gets BLANK cycles with every output off, then DWELL cycles with
// its strobe and column data on.
//
// Ports:
//   clock      in   system clock, rising edge
//   restart_n  in   asynchronous active-low reset
//   enable     in   scan enable; sampled in IDLE and at row boundaries only
//   leds       in   ROWS*COLS frame, bit r*COLS+c = row r / column c, 1 = lit
//   row_sel    out  one-hot row strobe (inverted when ACTIVE_LOW)
//   col_data   out  column data of the driven row (inverted when ACTIVE_LOW)
//   row_idx    out  row currently in BLANK or DRIVE
//   frame_done out  one-cycle pulse on the last DRIVE cycle of the last row
//   busy       out  high whenever not in IDLE
module matriz_scan_driver #(
   parameter int unsigned ROWS       = 10,
   parameter int unsigned COLS       = 10,
   parameter int unsigned DWELL      = 1000,
   parameter int unsigned BLANK      = 16,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                   clock,
   input  logic                   restart_n,
   input  logic                   enable,
   input  logic [ROWS*COLS-1:0]   leds,
   output logic [ROWS-1:0]        row_sel,
   output logic [COLS-1:0]        col_data,
   output logic [3:0]             row_idx,
   output logic                   frame_done,
   output logic                   busy
);

   localparam int unsigned FW    = ROWS * COLS;
   localparam int unsigned RIW   = 4;
   localparam int unsigned MAXC  = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int unsigned CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   // Pin-level "off" patterns; XOR with these applies the board polarity.
   localparam logic [ROWS-1:0] ROW_OFF = {ROWS{ACTIVE_LOW}};
   localparam logic [COLS-1:0] COL_OFF = {COLS{ACTIVE_LOW}};

   localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);
   localparam logic [RIW-1:0] ROW_LAST   = RIW'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [RIW-1:0]  r_row;
   logic [FW-1:0]   r_snap;
   logic [ROWS-1:0] r_row_sel;
   logic [COLS-1:0] r_col_data;
   logic            r_frame_done;
   logic            r_busy;

   state_t          w_state_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [RIW-1:0]  w_row_nxt;
   logic [FW-1:0]   w_snap_nxt;
   logic [ROWS-1:0] w_row_sel_nxt;
   logic [COLS-1:0] w_col_nxt;
   logic            w_frame_done_nxt;
   logic            w_busy_nxt;

   // State register and registered outputs.
   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_row        <= '0;
         r_snap       <= '0;
         r_row_sel    <= ROW_OFF;
         r_col_data   <= COL_OFF;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_row        <= w_row_nxt;
         r_snap       <= w_snap_nxt;
         r_row_sel    <= w_row_sel_nxt ^ ROW_OFF;
         r_col_data   <= w_col_nxt ^ COL_OFF;
         r_frame_done <= w_frame_done_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // Next state, then outputs decoded from the next state so every pin is a flop.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_row_nxt        = r_row;
      w_snap_nxt       = r_snap;
      w_row_sel_nxt    = '0;
      w_col_nxt        = '0;
      w_frame_done_nxt = 1'b0;
      w_busy_nxt       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               w_row_nxt   = '0;
               w_snap_nxt  = leds;
            end
         end
         ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = ST_DRIVE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_DRIVE: begin
            if (r_cnt == DWELL_LAST) begin
               w_cnt_nxt = '0;
               if (!enable) begin
                  w_state_nxt = ST_IDLE;
                  w_row_nxt   = '0;
               end else if (r_row == ROW_LAST) begin
                  // Frame boundary: start the next frame from a fresh snapshot.
                  w_state_nxt = ST_BLANK;
                  w_row_nxt   = '0;
                  w_snap_nxt  = leds;
               end else begin
                  w_state_nxt = ST_BLANK;
                  w_row_nxt   = r_row + RIW'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_row_nxt   = '0;
         end
      endcase

      // Strobe and data both come from the same next row, so they never mismatch.
      if (w_state_nxt == ST_DRIVE) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            w_row_sel_nxt[r] = (w_row_nxt == RIW'(r));
            if (w_row_nxt == RIW'(r)) begin
               w_col_nxt = w_snap_nxt[r*COLS +: COLS];
            end
         end
      end

      w_frame_done_nxt = (w_state_nxt == ST_DRIVE) && (w_cnt_nxt == DWELL_LAST) &&
                         (w_row_nxt == ROW_LAST);
      w_busy_nxt       = (w_state_nxt != ST_IDLE);
   end

   assign row_sel    = r_row_sel;
   assign col_data   = r_col_data;
   assign row_idx    = r_row;
   assign frame_done = r_frame_done;
   assign busy       = r_busy;

endmodule
